// File: rtl/mem_access.sv
// mem_access: memory pipeline stage issuing single-outstanding bus loads/stores,
// formatting load data and producing the MEM/WB register plus a forwarding source.
module mem_access #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_aluOut,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_wd,
  input  logic            in_isWriteBack,
  input  logic            in_isMemRead,
  input  logic            in_isMemWrite,
  input  logic [2:0]      in_memMode,
  output logic            ok_to_proceed,
  input  logic            ok_to_proceed_overall,
  output logic            dreq_valid,
  output logic            dreq_write,
  output logic [XLEN-1:0] dreq_addr,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_valid,
  input  logic [XLEN-1:0] dresp_data,
  output logic            out_valid,
  output logic [4:0]      out_wd,
  output logic            out_isWriteBack,
  output logic [XLEN-1:0] out_data,
  output logic            out_misaligned,
  output logic            out_bus_err,
  output logic            fwd_valid,
  output logic [4:0]      fwd_wd,
  output logic            fwd_ready,
  output logic [XLEN-1:0] fwd_data
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dreq_valid_q, dreq_valid_d;
  logic              dreq_write_q, dreq_write_d;
  logic [XLEN-1:0]   dreq_addr_q, dreq_addr_d;
  logic [7:0]        dreq_strobe_q, dreq_strobe_d;
  logic [XLEN-1:0]   dreq_data_q, dreq_data_d;
  logic [XLEN-1:0]   load_data_q, load_data_d;
  logic              err_q, err_d;
  logic              out_valid_q, out_valid_d;
  logic [4:0]        out_wd_q, out_wd_d;
  logic              out_wb_q, out_wb_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  logic              out_mis_q, out_mis_d;
  logic              out_err_q, out_err_d;

  logic [2:0]        off;
  logic [1:0]        size_log;
  logic              is_mem;
  logic              is_load;
  logic              misaligned;
  logic [7:0]        strobe_base;
  logic [7:0]        req_strobe;
  logic [XLEN-1:0]   req_wdata;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   fmt_data;

  assign off      = in_aluOut[2:0];
  assign size_log = in_memMode[1:0];
  assign is_mem   = in_valid & (in_isMemRead | in_isMemWrite);
  assign is_load  = in_valid & in_isMemRead;

  // Access geometry: alignment, byte enables and lane-replicated store data
  always_comb begin
    misaligned  = 1'b0;
    strobe_base = 8'hFF;
    req_wdata   = in_rs2;
    case (size_log)
      2'd0: begin
        misaligned  = 1'b0;
        strobe_base = 8'h01;
        req_wdata   = {(XLEN/8){in_rs2[7:0]}};
      end
      2'd1: begin
        misaligned  = off[0];
        strobe_base = 8'h03;
        req_wdata   = {(XLEN/16){in_rs2[15:0]}};
      end
      2'd2: begin
        misaligned  = |off[1:0];
        strobe_base = 8'h0F;
        req_wdata   = {(XLEN/32){in_rs2[31:0]}};
      end
      default: begin
        misaligned  = |off;
        strobe_base = 8'hFF;
        req_wdata   = in_rs2;
      end
    endcase
    req_strobe = strobe_base << off;
  end

  // The bus returns the aligned doubleword; bring the addressed lane down, then extend
  always_comb begin
    shifted  = dresp_data >> {off, 3'b000};
    fmt_data = shifted;
    case (size_log)
      2'd0: fmt_data = in_memMode[2] ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                     : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      2'd1: fmt_data = in_memMode[2] ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                     : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      2'd2: fmt_data = in_memMode[2] ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                     : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      default: fmt_data = shifted;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dreq_valid_d  = dreq_valid_q;
    dreq_write_d  = dreq_write_q;
    dreq_addr_d   = dreq_addr_q;
    dreq_strobe_d = dreq_strobe_q;
    dreq_data_d   = dreq_data_q;
    load_data_d   = load_data_q;
    err_d         = err_q;
    ok_to_proceed = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ok_to_proceed = ~is_mem | misaligned;
        if (is_mem && !misaligned) begin
          state_d       = ST_REQ;
          cnt_d         = '0;
          dreq_valid_d  = 1'b1;
          dreq_write_d  = in_isMemWrite;
          dreq_addr_d   = {in_aluOut[XLEN-1:3], 3'b000};
          dreq_strobe_d = req_strobe;
          dreq_data_d   = req_wdata;
          load_data_d   = '0;
          err_d         = 1'b0;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response in the final timeout cycle still wins over the abort
        if (dresp_valid) begin
          state_d      = ST_DONE;
          dreq_valid_d = 1'b0;
          load_data_d  = in_isMemRead ? fmt_data : '0;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d      = ST_DONE;
          dreq_valid_d = 1'b0;
          load_data_d  = '0;
          err_d        = 1'b1;
        end
      end
      ST_DONE: begin
        ok_to_proceed = 1'b1;
        dreq_valid_d  = 1'b0;
        if (ok_to_proceed_overall) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        dreq_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_wd_d    = out_wd_q;
    out_wb_d    = out_wb_q;
    out_data_d  = out_data_q;
    out_mis_d   = out_mis_q;
    out_err_d   = out_err_q;
    if (ok_to_proceed_overall) begin
      out_valid_d = in_valid;
      out_wd_d    = in_wd;
      out_wb_d    = in_isWriteBack & ~(is_mem & misaligned);
      out_mis_d   = is_mem & misaligned;
      out_err_d   = is_mem & ~misaligned & (state_q == ST_DONE) & err_q;
      if (is_load) begin
        out_data_d = misaligned ? '0 : load_data_q;
      end else begin
        out_data_d = in_aluOut;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      dreq_valid_q  <= 1'b0;
      dreq_write_q  <= 1'b0;
      dreq_addr_q   <= '0;
      dreq_strobe_q <= '0;
      dreq_data_q   <= '0;
      load_data_q   <= '0;
      err_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_wd_q      <= '0;
      out_wb_q      <= 1'b0;
      out_data_q    <= '0;
      out_mis_q     <= 1'b0;
      out_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dreq_valid_q  <= dreq_valid_d;
      dreq_write_q  <= dreq_write_d;
      dreq_addr_q   <= dreq_addr_d;
      dreq_strobe_q <= dreq_strobe_d;
      dreq_data_q   <= dreq_data_d;
      load_data_q   <= load_data_d;
      err_q         <= err_d;
      out_valid_q   <= out_valid_d;
      out_wd_q      <= out_wd_d;
      out_wb_q      <= out_wb_d;
      out_data_q    <= out_data_d;
      out_mis_q     <= out_mis_d;
      out_err_q     <= out_err_d;
    end
  end

  assign dreq_valid      = dreq_valid_q;
  assign dreq_write      = dreq_write_q;
  assign dreq_addr       = dreq_addr_q;
  assign dreq_strobe     = dreq_strobe_q;
  assign dreq_data       = dreq_data_q;
  assign out_valid       = out_valid_q;
  assign out_wd          = out_wd_q;
  assign out_isWriteBack = out_wb_q;
  assign out_data        = out_data_q;
  assign out_misaligned  = out_mis_q;
  assign out_bus_err     = out_err_q;

  // Load results are only usable once captured; everything else forwards aluOut
  assign fwd_valid = in_valid & (|in_wd) & in_isWriteBack;
  assign fwd_wd    = in_wd;
  assign fwd_ready = ~is_load | (state_q == ST_DONE);
  assign fwd_data  = (is_load && (state_q == ST_DONE)) ? load_data_q : in_aluOut;

endmodule
